mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It owns the HI/LO registers and executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It drives the `start`/`busy` pair that the hazard unit uses to stall any MDU instruction held in D. It models fixed multi-cycle latency with a down-counter, and commits results to HI/LO only when the operation retires.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `op`  in  4: E-stage MDU opcode.
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
  - 9–15 are treated as NONE.
- `a`  in  32: forwarded rs value (E stage).
- `b`  in  32: forwarded rt value (E stage).
- `start`  out  1: combinational.
  - High when `op` is 1–4 and `busy`=0.
- `busy`  out  1: registered; high while an operation is in flight.
- `hi`  out  32: current architectural HI.
- `lo`  out  32: current architectural LO.
- `out`  out  32: combinational read value.
  - HI when `op`=MFHI, LO when `op`=MFLO, else 0.

## Operation
- State:
  - `hi` and `lo`, 32 bits each.
  - `pend_hi` and `pend_lo`, 32 bits each.
  - `cnt`, 4+ bits, wide enough for max(`MULT_CYCLES`, `DIV_CYCLES`).
  - `pend_skip`, 1 bit: set for divide by zero.
- `busy` = (`cnt` != 0), taken from a register and not decoded from `op`.
- States:
  - IDLE (`cnt`=0).
  - RUN (`cnt`>0).
- IDLE, `op` in 1–4:
  - Compute the result into `pend_hi`/`pend_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to RUN.
- RUN, each edge:
  - Decrement `cnt`.
  - On the edge where `cnt` goes 1→0, copy `pend_hi`/`pend_lo` to `hi`/`lo`, unless `pend_skip` is set.
- Arithmetic:
  - MULT: signed 32×32→64. `hi` = product[63:32], `lo` = product[31:0].
  - MULTU: unsigned 32×32→64, same split.
  - DIV: signed. `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - DIVU: unsigned quotient to `lo`, remainder to `hi`.
- Divide by zero (`b`=0):
  - Full `DIV_CYCLES` busy period is still taken.
  - `hi`/`lo` are left unchanged (`pend_skip`=1).
- Signed overflow 0x80000000 / 0xFFFFFFFF:
  - `lo`=0x80000000, `hi`=0.
- MTHI/MTLO in IDLE: `hi` (or `lo`) ← `a` at the next edge; no busy.
- MFHI/MFLO: combinational read of the architectural `hi`/`lo`.
- Any `op` 1–4, 7 or 8 while `busy`=1:
  - Ignored: no state change, `start`=0.
  - The hazard unit prevents this case; the unit still defends against it.
- MFHI/MFLO while busy return the pre-operation `hi`/`lo`.
- `reset`:
  - Clears `hi`, `lo`, `pend_*` and `cnt` to 0, which deasserts `busy`.
  - An in-flight operation is discarded with no commit, including when reset lands on the retiring edge.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, `start`=0 when `op`=NONE, `out`=0.
- Issue cycle T: `op`=MULT, `start`=1, `busy`=0.
- Cycles T+1…T+`MULT_CYCLES`: `busy`=1, `start`=0.
- Retirement: `hi`/`lo` carry the new value from cycle T+`MULT_CYCLES`+1, when `busy`=0.
- Divide: same pattern with `DIV_CYCLES`.
- Back-to-back: a new MDU op is accepted in the first cycle with `busy`=0 and sees the just-committed `hi`/`lo`.
- MTHI at cycle T: visible on `hi`/`out` from cycle T+1.
- `start` and `out` are purely combinational from `op` and state, with no added latency. The hazard unit samples `start`|`busy` in the same cycle.

## Test plan
- MULT, `a`=0xFFFFFFFF, `b`=2:
  - `busy` high for 5 cycles.
  - Then `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFE.
  - MFLO then returns 0xFFFFFFFE.
- MULTU with the same operands: `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 busy cycles.
- DIV, 7 / 0xFFFFFFFE (−2): `lo`=0xFFFFFFFD, `hi`=1.
- DIV, 0xFFFFFFF9 (−7) / 2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- Both divides must show `busy` for exactly 10 cycles.
- MTHI `a`=0x1234, then DIVU with `b`=0:
  - `busy` high for 10 cycles.
  - `hi` stays 0x1234 and `lo` stays 0.
  - MFHI during busy returns 0x1234.
- MULT issued, MTLO and DIV presented during busy, reset asserted at busy cycle 3:
  - Ignored ops leave no effect.
  - After reset, `busy`=0 and `hi`=`lo`=0, with no commit on the following edges.
  - A subsequent MULT 3×4 yields `lo`=12 and `hi`=0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the E-stage datapath and the multiply/divide unit.
// The datapath owns op/a/b; the unit drives start/busy and the HI/LO views.
interface mult_div_unit_if;
    logic [3:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_start;
    logic        o_busy;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic [31:0] o_out;

    modport master (
        output i_op, i_a, i_b,
        input  o_start, o_busy, o_hi, o_lo, o_out
    );

    modport slave (
        input  i_op, i_a, i_b,
        output o_start, o_busy, o_hi, o_lo, o_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS E-stage multiply/divide unit: owns HI/LO, computes the result at issue and
// holds it in pend_* until a fixed-latency down-counter retires the operation.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  mdu
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W    = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]       r_hi, w_hi_nxt;
    logic [31:0]       r_lo, w_lo_nxt;
    logic [31:0]       r_pend_hi, w_pend_hi_nxt;
    logic [31:0]       r_pend_lo, w_pend_lo_nxt;
    logic              r_pend_skip, w_pend_skip_nxt;

    logic              w_is_mdu, w_is_div, w_is_sdiv, w_busy, w_start;
    logic [63:0]       w_smul, w_umul;
    logic [31:0]       w_a_mag, w_b_mag, w_dvd, w_dvs, w_q, w_r;
    logic [31:0]       w_res_hi, w_res_lo;

    assign w_is_mdu  = (mdu.i_op >= OP_MULT) && (mdu.i_op <= OP_DIVU);
    assign w_is_div  = (mdu.i_op == OP_DIV) || (mdu.i_op == OP_DIVU);
    assign w_is_sdiv = (mdu.i_op == OP_DIV);
    assign w_busy    = (r_cnt != CNT_ZERO);
    assign w_start   = w_is_mdu && !w_busy;

    // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
    assign w_smul  = {{32{mdu.i_a[31]}}, mdu.i_a} * {{32{mdu.i_b[31]}}, mdu.i_b};
    assign w_umul  = {32'd0, mdu.i_a} * {32'd0, mdu.i_b};
    assign w_a_mag = mdu.i_a[31] ? (32'd0 - mdu.i_a) : mdu.i_a;
    assign w_b_mag = mdu.i_b[31] ? (32'd0 - mdu.i_b) : mdu.i_b;
    assign w_dvd   = w_is_sdiv ? w_a_mag : mdu.i_a;
    assign w_dvs   = w_is_sdiv ? w_b_mag : mdu.i_b;

    // One unsigned divider on magnitudes; a zero divisor is swapped for 1 since the result is discarded.
    always_comb begin
        w_q = 32'd0;
        w_r = 32'd0;
        if (w_dvs != 32'd0) begin
            w_q = w_dvd / w_dvs;
            w_r = w_dvd % w_dvs;
        end else begin
            w_q = w_dvd;
            w_r = 32'd0;
        end
    end

    // Select the result of the issuing op; signed divide re-applies signs (0x80000000/-1 falls out as 0x80000000).
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (mdu.i_op)
            OP_MULT: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
            end
            OP_DIV: begin
                w_res_lo = (mdu.i_a[31] ^ mdu.i_b[31]) ? (32'd0 - w_q) : w_q;
                w_res_hi = mdu.i_a[31] ? (32'd0 - w_r) : w_r;
            end
            OP_DIVU: begin
                w_res_lo = w_q;
                w_res_hi = w_r;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
            end
        endcase
    end

    // Next-state logic: issue/MTHI/MTLO in IDLE, countdown and retire in RUN.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hi_nxt        = r_hi;
        w_lo_nxt        = r_lo;
        w_pend_hi_nxt   = r_pend_hi;
        w_pend_lo_nxt   = r_pend_lo;
        w_pend_skip_nxt = r_pend_skip;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_pend_hi_nxt   = w_res_hi;
                    w_pend_lo_nxt   = w_res_lo;
                    w_pend_skip_nxt = w_is_div && (mdu.i_b == 32'd0);
                    w_cnt_nxt       = w_is_div ? DIV_LOAD : MULT_LOAD;
                    w_state_nxt     = ST_RUN;
                end else if (mdu.i_op == OP_MTHI) begin
                    w_hi_nxt = mdu.i_a;
                end else if (mdu.i_op == OP_MTLO) begin
                    w_lo_nxt = mdu.i_a;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                    if (!r_pend_skip) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end else begin
                        w_hi_nxt = r_hi;
                        w_lo_nxt = r_lo;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State registers; reset wins over a retiring edge so nothing is committed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_skip <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hi        <= w_hi_nxt;
            r_lo        <= w_lo_nxt;
            r_pend_hi   <= w_pend_hi_nxt;
            r_pend_lo   <= w_pend_lo_nxt;
            r_pend_skip <= w_pend_skip_nxt;
        end
    end

    // Read port for MFHI/MFLO.
    always_comb begin
        case (mdu.i_op)
            OP_MFHI: mdu.o_out = r_hi;
            OP_MFLO: mdu.o_out = r_lo;
            default: mdu.o_out = 32'd0;
        endcase
    end

    assign mdu.o_start = w_start;
    assign mdu.o_busy  = w_busy;
    assign mdu.o_hi    = r_hi;
    assign mdu.o_lo    = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences and randomized traffic against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;

    logic clk;
    logic reset;
    mult_div_unit_if mif();

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    int          m_left = 0;
    logic        m_skip = 1'b0;

    // last sampled DUT outputs
    logic        s_start, s_busy;
    logic [31:0] s_out, s_hi, s_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive, sample mid-cycle, compare with model, advance model.
    task automatic drive_cycle(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic rst);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        @(negedge clk);
        mif.i_op = op;
        mif.i_a  = a;
        mif.i_b  = b;
        reset    = rst;
        #1;
        s_start = mif.o_start;
        s_busy  = mif.o_busy;
        s_out   = mif.o_out;
        s_hi    = mif.o_hi;
        s_lo    = mif.o_lo;
        check("start", {31'd0, s_start}, {31'd0, (op >= MULT && op <= DIVU && m_left == 0)});
        check("busy",  {31'd0, s_busy},  {31'd0, (m_left != 0)});
        check("out",   s_out, (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0);
        check("hi",    s_hi, m_hi);
        check("lo",    s_lo, m_lo);
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
            m_left = 0; m_skip = 1'b0;
        end else if (m_left == 0) begin
            case (op)
                MULT: begin
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                    q = sa * sb;
                    m_phi = q[63:32]; m_plo = q[31:0]; m_skip = 1'b0; m_left = MC;
                end
                MULTU: begin
                    ua = {32'd0, a}; ub = {32'd0, b};
                    p = ua * ub;
                    m_phi = p[63:32]; m_plo = p[31:0]; m_skip = 1'b0; m_left = MC;
                end
                DIV: begin
                    m_left = DC;
                    m_skip = (b == 32'd0);
                    if (b != 32'd0) begin
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                        q = sa / sb; r = sa % sb;
                        m_plo = q[31:0]; m_phi = r[31:0];
                    end
                end
                DIVU: begin
                    m_left = DC;
                    m_skip = (b == 32'd0);
                    if (b != 32'd0) begin
                        ua = {32'd0, a}; ub = {32'd0, b};
                        p = ua / ub; m_plo = p[31:0];
                        p = ua % ub; m_phi = p[31:0];
                    end
                end
                MTHI: m_hi = a;
                MTLO: m_lo = a;
                default: ;
            endcase
        end else begin
            m_left--;
            if (m_left == 0 && !m_skip) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end
        @(posedge clk);
    endtask

    // Idle until busy drops (bounded); returns number of busy cycles seen.
    task automatic wait_idle(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            drive_cycle(NONE, 32'd0, 32'd0, 1'b0);
            if (!s_busy) break;
            n++;
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MC};
        vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
        vecs[2] = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        vecs[3] = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[5] = '{DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, DC};
        vecs[6] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
        vecs[7] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};

        mif.i_op = NONE; mif.i_a = 32'd0; mif.i_b = 32'd0; reset = 1'b1;
        repeat (2) @(posedge clk);

        // reset state
        drive_cycle(NONE, 32'd0, 32'd0, 1'b0);
        check("rst_busy", {31'd0, s_busy}, 32'd0);
        check("rst_start", {31'd0, s_start}, 32'd0);
        check("rst_out", s_out, 32'd0);
        check("rst_hi", s_hi, 32'd0);
        check("rst_lo", s_lo, 32'd0);

        // directed vector table
        foreach (vecs[i]) begin
            drive_cycle(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            check("vec_issue_start", {31'd0, s_start}, 32'd1);
            wait_idle(n);
            check("vec_busy_cycles", n, vecs[i].cyc);
            check("vec_hi", s_hi, vecs[i].hi);
            check("vec_lo", s_lo, vecs[i].lo);
            drive_cycle(MFLO, 32'd0, 32'd0, 1'b0);
            check("vec_mflo", s_out, vecs[i].lo);
            drive_cycle(MFHI, 32'd0, 32'd0, 1'b0);
            check("vec_mfhi", s_out, vecs[i].hi);
        end

        // MTHI then DIVU by zero: full busy period, no commit
        drive_cycle(NONE, 32'd0, 32'd0, 1'b1);
        drive_cycle(MTHI, 32'h1234, 32'd0, 1'b0);
        drive_cycle(MFHI, 32'd0, 32'd0, 1'b0);
        check("mthi_next_cycle", s_out, 32'h1234);
        drive_cycle(DIVU, 32'd5, 32'd0, 1'b0);
        drive_cycle(MFHI, 32'd0, 32'd0, 1'b0);
        check("dz_mfhi_busy", s_out, 32'h1234);
        check("dz_busy", {31'd0, s_busy}, 32'd1);
        wait_idle(n);
        check("dz_busy_cycles", n + 1, DC);
        check("dz_hi", s_hi, 32'h1234);
        check("dz_lo", s_lo, 32'd0);

        // ignored ops during busy, then reset at busy cycle 3
        drive_cycle(MULT, 32'h10, 32'h20, 1'b0);
        drive_cycle(MTLO, 32'hDEAD, 32'd0, 1'b0);
        check("ign_mtlo_start", {31'd0, s_start}, 32'd0);
        drive_cycle(DIV, 32'd9, 32'd3, 1'b0);
        check("ign_div_start", {31'd0, s_start}, 32'd0);
        drive_cycle(NONE, 32'd0, 32'd0, 1'b1);
        check("pre_rst_busy", {31'd0, s_busy}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            drive_cycle(NONE, 32'd0, 32'd0, 1'b0);
            check("post_rst_busy", {31'd0, s_busy}, 32'd0);
            check("post_rst_hi", s_hi, 32'd0);
            check("post_rst_lo", s_lo, 32'd0);
        end
        drive_cycle(MULT, 32'd3, 32'd4, 1'b0);
        wait_idle(n);
        check("m34_cycles", n, MC);
        check("m34_lo", s_lo, 32'd12);
        check("m34_hi", s_hi, 32'd0);

        // reset landing exactly on the retiring edge
        drive_cycle(MULT, 32'd7, 32'd7, 1'b0);
        repeat (MC - 1) drive_cycle(NONE, 32'd0, 32'd0, 1'b0);
        drive_cycle(NONE, 32'd0, 32'd0, 1'b1);
        drive_cycle(NONE, 32'd0, 32'd0, 1'b0);
        check("rst_retire_lo", s_lo, 32'd0);
        check("rst_retire_busy", {31'd0, s_busy}, 32'd0);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic [3:0]  rop;
            logic [31:0] ra, rb;
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 15) == 0) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            drive_cycle(rop, ra, rb, ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
